id_ex_hazard_ctrl: RTL and testbench

//   Pipeline hazard controller for the ID/EX stage boundary. Detects load-use hazards,

---
 rtl/id_ex_hazard_ctrl.sv | 122 ++++++++++++
 tb/tb_id_ex_hazard_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_hazard_ctrl.sv
// ID/EX hazard controller: load-use stall, branch flush, data-memory wait freeze
// with a sticky watchdog, plus saturating stall/flush event counters.
module id_ex_hazard_ctrl #(
  parameter int unsigned RA_W     = 5,
  parameter int unsigned MAX_WAIT = 15,
  parameter int unsigned WCNT_W   = 4,
  parameter int unsigned PCNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [RA_W-1:0]   ifid_rs,
  input  logic [RA_W-1:0]   ifid_rt,
  input  logic              ifid_uses_rt,
  input  logic              idex_memread,
  input  logic [RA_W-1:0]   idex_rt,
  input  logic              branch_taken,
  input  logic              mem_busy,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              idex_bubble,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              pipe_freeze,
  output logic              timeout,
  output logic [PCNT_W-1:0] stall_cnt,
  output logic [PCNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, TIMEOUT} state_t;

  state_t            state, state_nxt;
  logic [WCNT_W-1:0] wcnt, wcnt_nxt;
  logic              load_use;
  logic              stall_inc, flush_inc;

  assign load_use = idex_memread && (idex_rt != '0) &&
                    ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));

  always_comb begin
    state_nxt   = state;
    wcnt_nxt    = wcnt;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    pipe_freeze = 1'b0;
    timeout     = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;

    case (state)
      RUN, MEM_WAIT: begin
        if (mem_busy) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          pipe_freeze = 1'b1;
          if (state == RUN) begin
            state_nxt = MEM_WAIT;
            wcnt_nxt  = WCNT_W'(1);
          end else if (wcnt == WCNT_W'(MAX_WAIT)) begin
            state_nxt = TIMEOUT;
          end else begin
            wcnt_nxt = wcnt + 1'b1;
          end
        end else begin
          // Leaving MEM_WAIT services branch/load-use in the same cycle.
          state_nxt = RUN;
          wcnt_nxt  = '0;
          if (branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            flush_inc  = 1'b1;
          end else if (load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            stall_inc   = 1'b1;
          end
        end
      end
      TIMEOUT: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        pipe_freeze = 1'b1;
        timeout     = 1'b1;
      end
      default: begin
        state_nxt = RUN;
        wcnt_nxt  = '0;
      end
    endcase

    // While reset is held the pipeline is frozen with a bubble staged.
    if (!reset_n) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      pipe_freeze = 1'b1;
      idex_bubble = 1'b1;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      timeout     = 1'b0;
      stall_inc   = 1'b0;
      flush_inc   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= RUN;
      wcnt      <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (flush_inc && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_hazard_ctrl.sv
// Bench for id_ex_hazard_ctrl: vector table, directed corner sequences and
// randomized traffic against a consecutive-busy-count reference model.
module tb_id_ex_hazard_ctrl;

  localparam int MAX_WAIT = 15;
  localparam int PMAX     = 65535;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [4:0]  ifid_rs = '0, ifid_rt = '0, idex_rt = '0;
  logic        ifid_uses_rt = 1'b0, idex_memread = 1'b0, branch_taken = 1'b0, mem_busy = 1'b0;
  logic        pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush, pipe_freeze, timeout;
  logic [15:0] stall_cnt, flush_cnt;

  id_ex_hazard_ctrl #(.RA_W(5), .MAX_WAIT(MAX_WAIT), .WCNT_W(4), .PCNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
    .idex_memread(idex_memread), .idex_rt(idex_rt),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_bubble(idex_bubble),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .pipe_freeze(pipe_freeze),
    .timeout(timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: run length of consecutive busy cycles, sticky timeout flag, event tallies.
  int busy_run = 0;
  bit m_to     = 1'b0;
  int m_stall  = 0;
  int m_flush  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic bit m_load_use();
    return idex_memread && idex_rt != 0 &&
           (idex_rt == ifid_rs || (ifid_uses_rt && idex_rt == ifid_rt));
  endfunction

  // {pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush, pipe_freeze}
  function automatic logic [5:0] m_out();
    if (!reset_n)            return 6'b001001;
    if (m_to || mem_busy)    return 6'b000001;
    if (branch_taken)        return 6'b110110;
    if (m_load_use())        return 6'b001000;
    return 6'b110000;
  endfunction

  function automatic logic [5:0] dut_out();
    return {pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush, pipe_freeze};
  endfunction

  task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                        input logic mr, input logic [4:0] xrt, input logic br, input logic busy);
    ifid_rs = rs; ifid_rt = rt; ifid_uses_rt = uses;
    idex_memread = mr; idex_rt = xrt; branch_taken = br; mem_busy = busy;
  endtask

  // Called just after a negedge with inputs applied; returns just after the next negedge.
  task automatic cycle(input bit chk);
    #1;
    if (chk) begin
      check("ctrl_outputs", 32'(dut_out()), 32'(m_out()));
      check("timeout", 32'(timeout), 32'(m_to));
    end
    @(posedge clk);
    if (!m_to) begin
      if (mem_busy) begin
        busy_run++;
        if (busy_run == MAX_WAIT + 1) m_to = 1'b1;
      end else begin
        busy_run = 0;
        if (branch_taken)      m_flush = (m_flush < PMAX) ? m_flush + 1 : PMAX;
        else if (m_load_use()) m_stall = (m_stall < PMAX) ? m_stall + 1 : PMAX;
      end
    end
    @(negedge clk);
    #1;
    if (chk) begin
      check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
      check("flush_cnt", 32'(flush_cnt), 32'(m_flush));
    end
  endtask

  // Asserts reset mid-cycle (asynchronously), checks forced values, releases at negedge.
  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    check("rst_outputs", 32'(dut_out()), 32'(6'b001001));
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    check("rst_flush_cnt", 32'(flush_cnt), 32'd0);
    busy_run = 0; m_to = 1'b0; m_stall = 0; m_flush = 0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
  endtask

  typedef struct {
    logic [4:0] rs, rt;
    logic       uses, mr;
    logic [4:0] xrt;
    logic       br, busy;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int burst;
    vecs[0]  = '{5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 6'b001000}; // lw rs hit
    vecs[1]  = '{5'd8, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 6'b110000}; // no match
    vecs[2]  = '{5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 6'b110000}; // $zero never stalls
    vecs[3]  = '{5'd1, 5'd8, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 6'b110000}; // rt match, rt unused
    vecs[4]  = '{5'd1, 5'd8, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 6'b001000}; // rt match, rt used
    vecs[5]  = '{5'd8, 5'd8, 1'b1, 1'b0, 5'd8, 1'b0, 1'b0, 6'b110000}; // not a load
    vecs[6]  = '{5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 6'b110110}; // branch beats load-use
    vecs[7]  = '{5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1, 6'b000001}; // busy beats branch
    vecs[8]  = '{5'd3, 5'd4, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 6'b110000}; // leave wait, idle
    vecs[9]  = '{5'd3, 5'd4, 1'b1, 1'b0, 5'd5, 1'b0, 1'b1, 6'b000001}; // busy again
    vecs[10] = '{5'd2, 5'd6, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 6'b001000}; // load-use on exit

    @(negedge clk);
    #1;
    check("rst_hold_outputs", 32'(dut_out()), 32'(6'b001001));
    check("rst_hold_stall_cnt", 32'(stall_cnt), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;

    // Test 1: single load-use stall, then normal flow.
    set_in(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
    cycle(1'b1);
    check("t1_stall_cnt_one", 32'(stall_cnt), 32'd1);
    set_in(5'd8, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    cycle(1'b1);
    check("t1_enables_back", 32'({pc_write, ifid_write}), 32'b11);

    // Vector table.
    do_reset();
    for (int i = 0; i < 11; i++) begin
      set_in(vecs[i].rs, vecs[i].rt, vecs[i].uses, vecs[i].mr, vecs[i].xrt, vecs[i].br, vecs[i].busy);
      #1;
      check($sformatf("vec%0d_outputs", i), 32'(dut_out()), 32'(vecs[i].exp));
      cycle(1'b1);
    end

    // Test 3: branch with simultaneous load-use.
    do_reset();
    set_in(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0);
    cycle(1'b1);
    check("t3_flush_cnt", 32'(flush_cnt), 32'd1);
    check("t3_stall_cnt", 32'(stall_cnt), 32'd0);

    // Test 4: three busy cycles with branch held, flush on the busy-drop cycle.
    for (int i = 0; i < 3; i++) begin
      set_in(5'd1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1);
      #1;
      check("t4_no_flush_while_busy", 32'({ifid_flush, idex_flush, pipe_freeze}), 32'b001);
      cycle(1'b1);
    end
    check("t4_flush_cnt_held", 32'(flush_cnt), 32'd1);
    set_in(5'd1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0);
    #1;
    check("t4_flush_on_drop", 32'({ifid_flush, idex_flush}), 32'b11);
    cycle(1'b1);
    check("t4_flush_cnt", 32'(flush_cnt), 32'd2);

    // Test 5: 15 busy cycles do not time out, the 16th does; timeout is sticky.
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    for (int i = 0; i < MAX_WAIT; i++) cycle(1'b1);
    check("t5_no_timeout_at_15", 32'(timeout), 32'd0);
    cycle(1'b1);
    check("t5_timeout_at_16", 32'(timeout), 32'd1);
    set_in(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1);
    check("t5_timeout_sticky", 32'(timeout), 32'd1);
    do_reset();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    cycle(1'b1);
    check("t5_run_after_reset", 32'({timeout, pc_write}), 32'b01);

    // Reset in the middle of a wait and of a stall.
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    cycle(1'b1);
    do_reset();
    set_in(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
    cycle(1'b1);
    do_reset();

    // Randomized traffic.
    burst = 0;
    for (int i = 0; i < 1500; i++) begin
      logic busy;
      busy = 1'b0;
      if (burst > 0) begin
        busy = 1'b1;
        burst--;
      end else if ($urandom_range(0, 29) == 0) begin
        burst = $urandom_range(0, 19);
        busy  = 1'b1;
      end
      set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
             1'($urandom), 5'($urandom_range(0, 3)), ($urandom_range(0, 4) == 0), busy);
      cycle(1'b1);
      if ((m_to && $urandom_range(0, 7) == 0) || $urandom_range(0, 199) == 0) do_reset();
    end

    // Test 6: stall counter saturation.
    do_reset();
    set_in(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
    for (int i = 0; i < PMAX; i++) cycle(1'b0);
    check("t6_stall_cnt_max", 32'(stall_cnt), 32'hFFFF);
    cycle(1'b1);
    check("t6_stall_cnt_saturated", 32'(stall_cnt), 32'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
